// File: rtl/cache_pkg.sv
// Shared types and default sizing for the cache arbiter.
package cache_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick. On a tie, the requester not granted last wins.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       gnt_id,
    output logic       any
);

    // Select the winner from the current valid pair and the last grant.
    always_comb begin
        any    = |valid;
        gnt_id = 1'b0;
        case (valid)
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last_grant;
            default: gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates two requesters onto a single cache_controller port, with a
// sticky watchdog that forces completion if the cache never answers.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; arbitrate and latch the winner's request
// BUSY  | request presented to the cache; waiting for done_cache/timeout
// RESP  | one-cycle done pulse and read data to the granted requester
module cache_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_valid,
    input  logic              p0_req_type,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req_valid,
    input  logic              p1_req_type,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              req_valid,
    output logic              req_type,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              done_cache,
    input  logic [DATA_W-1:0] rdata_cache,
    output logic              grant_id,
    output logic              timeout_err
);

    // Sized so the count can reach TIMEOUT without wrapping.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t        state, state_nxt;
    logic              last_grant;
    logic              pick_id;
    logic              pick_any;
    logic              timeout_hit;
    logic [CNT_W-1:0]  wd_cnt;
    logic              lat_type;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] p0_rdata_q;
    logic [DATA_W-1:0] p1_rdata_q;

    rr_pick2 u_pick (
        .valid      ({p1_req_valid, p0_req_valid}),
        .last_grant (last_grant),
        .gnt_id     (pick_id),
        .any        (pick_any)
    );

    // A real completion in the same cycle takes precedence over the watchdog.
    assign timeout_hit = (state == BUSY) && !done_cache &&
                         (wd_cnt == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = BUSY;
            BUSY:    if (done_cache || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; done is gated so a reset mid-flight never pulses it.
    always_comb begin
        req_valid = (state == BUSY);
        p0_done   = (state == RESP) && !grant_id;
        p1_done   = (state == RESP) &&  grant_id;
    end

    // Grant latching, watchdog and response capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_id    <= 1'b0;
            last_grant  <= 1'b1;
            lat_type    <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id   <= pick_id;
                        last_grant <= pick_id;
                        lat_type   <= pick_id ? p1_req_type : p0_req_type;
                        lat_addr   <= pick_id ? p1_addr     : p0_addr;
                        lat_wdata  <= pick_id ? p1_wdata    : p0_wdata;
                        wd_cnt     <= '0;
                    end
                end
                BUSY: begin
                    wd_cnt <= wd_cnt + CNT_W'(1);
                    if (done_cache) begin
                        if (grant_id) p1_rdata_q <= rdata_cache;
                        else          p0_rdata_q <= rdata_cache;
                    end else if (timeout_hit) begin
                        timeout_err <= 1'b1;
                        if (grant_id) p1_rdata_q <= '0;
                        else          p0_rdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_type = lat_type;
    assign addr     = lat_addr;
    assign wdata    = lat_wdata;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a completion scoreboard.
module tb_cache_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          p0_req_valid, p0_req_type;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_done;
    logic [DW-1:0] p0_rdata;
    logic          p1_req_valid, p1_req_type;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_done;
    logic [DW-1:0] p1_rdata;
    logic          req_valid, req_type;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          done_cache;
    logic [DW-1:0] rdata_cache;
    logic          grant_id;
    logic          timeout_err;

    int   tests;
    int   fails;
    exp_t sb[$];

    cache_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(255)) dut (
        .clk          (clk),
        .rst          (rst),
        .p0_req_valid (p0_req_valid),
        .p0_req_type  (p0_req_type),
        .p0_addr      (p0_addr),
        .p0_wdata     (p0_wdata),
        .p0_done      (p0_done),
        .p0_rdata     (p0_rdata),
        .p1_req_valid (p1_req_valid),
        .p1_req_type  (p1_req_type),
        .p1_addr      (p1_addr),
        .p1_wdata     (p1_wdata),
        .p1_done      (p1_done),
        .p1_rdata     (p1_rdata),
        .req_valid    (req_valid),
        .req_type     (req_type),
        .addr         (addr),
        .wdata        (wdata),
        .done_cache   (done_cache),
        .rdata_cache  (rdata_cache),
        .grant_id     (grant_id),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called in the RESP cycle: compare the done pulse and read data against the queue head.
    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s scoreboard empty observed_done=%0b%0b", tag, p1_done, p0_done);
            return;
        end
        e = sb.pop_front();
        check({tag, "_req_valid"}, 64'(req_valid), 64'(0));
        check({tag, "_p0_done"}, 64'(p0_done), 64'(e.port == 1'b0));
        check({tag, "_p1_done"}, 64'(p1_done), 64'(e.port == 1'b1));
        check({tag, "_rdata"}, 64'(e.port ? p1_rdata : p0_rdata), 64'(e.data));
    endtask

    // Entered in the first BUSY cycle; stays busy for extra cycles, then completes.
    task automatic serve(input string tag, input int extra, input logic [DW-1:0] data);
        for (int i = 0; i < extra; i++) step();
        check({tag, "_busy"}, 64'(req_valid), 64'(1));
        done_cache  = 1'b1;
        rdata_cache = data;
        step();
        done_cache  = 1'b0;
        rdata_cache = '0;
        pop_check(tag);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    int busy_n;

    initial begin
        clk = 1'b0;
        tests = 0;
        fails = 0;
        p0_req_valid = 0; p0_req_type = 0; p0_addr = '0; p0_wdata = '0;
        p1_req_valid = 0; p1_req_type = 0; p1_addr = '0; p1_wdata = '0;
        done_cache = 0; rdata_cache = '0;
        rst = 1'b0;
        step();
        step();

        // reset state
        check("rst_req_valid", 64'(req_valid), 64'(0));
        check("rst_done", 64'({p1_done, p0_done}), 64'(0));
        check("rst_rdata", 64'({p1_rdata, p0_rdata}), 64'(0));
        check("rst_grant", 64'(grant_id), 64'(0));
        check("rst_addr", 64'(addr), 64'(0));
        check("rst_timeout", 64'(timeout_err), 64'(0));

        // single p0 read
        rst = 1'b1;
        p0_req_valid = 1; p0_req_type = 0; p0_addr = 32'h40;
        sb.push_back('{port: 1'b0, data: 32'hDEADBEEF});
        step();
        check("t1_grant", 64'(grant_id), 64'(0));
        check("t1_addr", 64'(addr), 64'h40);
        check("t1_type", 64'(req_type), 64'(0));
        serve("t1", 2, 32'hDEADBEEF);
        p0_req_valid = 0;
        step();
        check("t1_done_clear", 64'({p1_done, p0_done}), 64'(0));
        check("t1_rdata_hold", 64'(p0_rdata), 64'hDEADBEEF);

        // tie after reset, then alternation while both stay valid
        reset_dut();
        p0_req_valid = 1; p0_addr = 32'h100;
        p1_req_valid = 1; p1_addr = 32'h200;
        step();
        check("t2a_grant", 64'(grant_id), 64'(0));
        check("t2a_addr", 64'(addr), 64'h100);
        sb.push_back('{port: 1'b0, data: 32'hA0A0_0001});
        serve("t2a", 0, 32'hA0A0_0001);
        step();
        step();
        check("t2b_grant", 64'(grant_id), 64'(1));
        check("t2b_addr", 64'(addr), 64'h200);
        sb.push_back('{port: 1'b1, data: 32'hB0B0_0002});
        serve("t2b", 1, 32'hB0B0_0002);
        step();
        step();
        check("t2c_grant", 64'(grant_id), 64'(0));
        check("t2c_addr", 64'(addr), 64'h100);
        sb.push_back('{port: 1'b0, data: 32'hA0A0_0003});
        serve("t2c", 0, 32'hA0A0_0003);
        p0_req_valid = 0;
        p1_req_valid = 0;
        step();

        // p1 write; requester inputs change and valid drops mid-BUSY
        p1_req_valid = 1; p1_req_type = 1; p1_addr = 32'h80; p1_wdata = 32'h1234;
        step();
        check("t3_grant", 64'(grant_id), 64'(1));
        check("t3_type", 64'(req_type), 64'(1));
        check("t3_addr", 64'(addr), 64'h80);
        check("t3_wdata", 64'(wdata), 64'h1234);
        p1_addr = 32'h99; p1_wdata = 32'h5555; p1_req_type = 0;
        p0_addr = 32'hFFF; p0_wdata = 32'h7777;
        step();
        check("t3_addr_hold", 64'(addr), 64'h80);
        check("t3_wdata_hold", 64'(wdata), 64'h1234);
        check("t3_type_hold", 64'(req_type), 64'(1));
        p1_req_valid = 0;
        sb.push_back('{port: 1'b1, data: 32'hCAFE0001});
        serve("t3", 1, 32'hCAFE0001);
        check("t3_addr_resp", 64'(addr), 64'h80);
        step();

        // watchdog: cache never answers
        p0_req_valid = 1; p0_req_type = 0; p0_addr = 32'h300;
        step();
        check("t4_no_err_yet", 64'(timeout_err), 64'(0));
        sb.push_back('{port: 1'b0, data: 32'h0});
        busy_n = 0;
        for (int g = 0; g < 400 && !(p0_done || p1_done); g++) begin
            if (req_valid) busy_n++;
            step();
        end
        check("t4_busy_cycles", 64'(busy_n), 64'(255));
        check("t4_timeout_err", 64'(timeout_err), 64'(1));
        pop_check("t4");
        p0_req_valid = 0;
        step();
        step();
        check("t4_sticky", 64'(timeout_err), 64'(1));
        check("t4_done_clear", 64'(p0_done), 64'(0));
        p1_req_valid = 1; p1_req_type = 0; p1_addr = 32'h10;
        step();
        sb.push_back('{port: 1'b1, data: 32'h77});
        serve("t4b", 0, 32'h77);
        check("t4_sticky2", 64'(timeout_err), 64'(1));
        p1_req_valid = 0;
        step();

        // reset mid-BUSY aborts; stray done_cache in IDLE ignored
        p1_req_valid = 1; p1_addr = 32'h500;
        step();
        check("t5_busy", 64'(req_valid), 64'(1));
        step();
        rst = 1'b0;
        step();
        check("t5_req_valid", 64'(req_valid), 64'(0));
        check("t5_done", 64'({p1_done, p0_done}), 64'(0));
        check("t5_timeout_clr", 64'(timeout_err), 64'(0));
        check("t5_rdata_clr", 64'(p1_rdata), 64'(0));
        rst = 1'b1;
        p1_req_valid = 0;
        done_cache = 1; rdata_cache = 32'h5A5A5A5A;
        step();
        check("t5_stray_done", 64'({p1_done, p0_done}), 64'(0));
        check("t5_stray_valid", 64'(req_valid), 64'(0));
        done_cache = 0; rdata_cache = '0;
        step();
        check("t5_idle_done", 64'({p1_done, p0_done}), 64'(0));
        check("t5_idle_rdata", 64'(p1_rdata), 64'(0));

        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 Port rst, input, 1: synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-003 Ports p0_req_valid / p1_req_valid, input, 1: requester 0/1 holds high until its done pulse.
REQ-004 Ports p0_req_type / p1_req_type, input, 1: 0 = read, 1 = write.
REQ-005 Ports p0_addr / p1_addr, input, ADDR_W: request address.
REQ-006 Ports p0_wdata / p1_wdata, input, DATA_W: write data.
REQ-007 Ports p0_done / p1_done, output, 1: one-cycle completion pulse to the granted requester.
REQ-008 Ports p0_rdata / p1_rdata, output, DATA_W: read data, valid in the done cycle.
REQ-009 Ports req_valid, req_type, addr, wdata, outputs (1/1/ADDR_W/DATA_W): request to cache_controller.
REQ-010 Ports done_cache, input, 1, and rdata_cache, input, DATA_W: completion and read data from cache_controller.
REQ-011 Port grant_id, output, 1: requester currently owning the cache; valid only while busy.
REQ-012 Port timeout_err, output, 1: sticky watchdog flag.
REQ-013 Parameters: ADDR_W default 32, address width; DATA_W default 32, data width; TIMEOUT default 255, max BUSY cycles.

Function
REQ-014 FSM states: IDLE, BUSY, RESP.
REQ-015 IDLE: if any pX_req_valid, grant one requester, latch its type/addr/wdata, go to BUSY; otherwise stay.
REQ-016 Single requester valid: that requester is granted.
REQ-017 Both valid in the same cycle: the requester not granted last (last_grant pointer) is granted.
REQ-018 last_grant updates to the granted id on every grant.
REQ-019 BUSY: req_valid = 1; req_type/addr/wdata driven from latched registers, stable for the whole of BUSY.
REQ-020 BUSY and done_cache = 1: capture rdata_cache, go to RESP; req_valid drops to 0 in RESP.
REQ-021 RESP: exactly one cycle; pX_done = 1 for the granted id only; pX_rdata = captured data; next state IDLE.
REQ-022 Minimum latency: grant cycle (IDLE) -> BUSY -> done_cache seen -> RESP (done) -> IDLE.
REQ-023 IDLE after RESP re-arbitrates. A requester still asserting valid is treated as a new request.
REQ-024 A requester dropping valid during BUSY is ignored; the transaction completes and done still pulses.
REQ-025 done_cache while in IDLE or RESP is ignored.
REQ-026 Input changes from the non-granted requester never alter the latched request.
REQ-027 Watchdog counter: cleared on entry to BUSY, increments each BUSY cycle.
REQ-028 Counter reaching TIMEOUT sets timeout_err, forces RESP with rdata = 0, and pulses done.
REQ-029 timeout_err stays set until reset.
REQ-030 Counter width = clog2(TIMEOUT+1); it never wraps.
REQ-031 Outside RESP, p0_done/p1_done = 0 and p0_rdata/p1_rdata hold their last value.

Reset
REQ-032 While rst = 0 at a clock edge: state = IDLE, req_valid = 0, p0_done = p1_done = 0, all rdata/latched regs = 0, grant_id = 0, last_grant = 1 (port 0 wins first tie), counter = 0, timeout_err = 0.
REQ-033 Reset asserted during BUSY or RESP aborts the transaction; no done pulse is emitted.

Structure
REQ-034 cache_pkg holds the arb_state_t enum (IDLE/BUSY/RESP) and the default ADDR_W/DATA_W/TIMEOUT constants.
REQ-035 One sub-module, rr_pick2: combinational 2-way round-robin selection (valid[1:0], last_grant) -> (gnt_id, any).

Verification
REQ-036 Only p0 read of addr 0x40; done_cache after 3 BUSY cycles with rdata 0xDEADBEEF -> p0_done one cycle, p0_rdata = 0xDEADBEEF, p1_done = 0.
REQ-037 p0 and p1 valid together after reset -> p0 granted first; both held -> p1 granted next; then p0 (alternation).
REQ-038 p1 write, addr 0x80, wdata 0x1234; p1 changes addr mid-BUSY -> addr output stays 0x80 until RESP.
REQ-039 done_cache never asserted -> timeout_err = 1 after 255 BUSY cycles, done pulses with rdata = 0, flag sticky.
REQ-040 rst = 0 mid-BUSY -> next edge req_valid = 0, state IDLE, no done pulse; a stray done_cache in IDLE is ignored.
